load_store_unit: RTL

Sits directly upstream of data_memory. It converts byte-addressed load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) from the execute stage into word-indexed data_memory accesses. Sub-word stores use a read-modify-write sequence; loads are lane-extracted and sign- or zero-extended. A misaligned request raises an error and is never issued to memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_unit.sv | 59 +++++
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   DATA_W        - data word width (fixed at 32)
//   SZ_BYTE/HALF/WORD - req_size encodings (3 is reserved)
//   lsu_state_e   - sequencing FSM states
//   is_misaligned - alignment check for a (size, addr[1:0]) pair
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    // The reserved size encoding is always reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad_s;
        case (size)
            SZ_BYTE: bad_s = 1'b0;
            SZ_HALF: bad_s = addr_lo[0];
            SZ_WORD: bad_s = (addr_lo != 2'b00);
            default: bad_s = 1'b1;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: purely combinational little-endian lane logic.
// Ports:
//   addr_lo       in  byte offset within the word (addr[1:0])
//   size          in  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   load_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   rdata         in  word read back from memory
//   wdata         in  right-justified store data
//   load_data     out lane-extracted, extended load result
//   merge_data    out rdata with the target lane replaced by wdata
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [4:0]  bit_off_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte k starts at bit 8k; half h starts at bit 16h (h = addr[1]).
    assign bit_off_s = {addr_lo, 3'b000};
    assign byte_s    = rdata[bit_off_s +: 8];
    assign half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Load extract and sign/zero extension.
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = load_unsigned ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = load_unsigned ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            SZ_WORD: load_data = rdata;
            default: load_data = rdata;
        endcase
    end

    // Store merge: only the addressed lane takes new data.
    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: merge_data[bit_off_s +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: merge_data = wdata;
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests
// into word-indexed data_memory accesses. Sub-word stores are done as
// read-modify-write; misaligned requests answer with resp_err and never
// touch memory.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_size, req_unsigned, req_addr, req_wdata  request fields
//   resp_valid/resp_rdata/resp_err single-cycle completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata  data_memory port
//     (mem_rdata is valid the cycle after mem_read)
// Build option: define LSU_BOUNDS_CHECK_EN to also reject word indices
// >= MEM_DEPTH with resp_err and no memory access.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import lsu_pkg::*;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(MEM_DEPTH);

    lsu_state_e        state_r;
    lsu_state_e        state_next_s;

    logic              write_r;
    logic [1:0]        size_r;
    logic              unsigned_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;

    logic              range_err_s;
    logic              req_err_s;
    logic              accept_s;
    logic [ADDR_W-1:0] word_idx_r;

    logic              req_ready_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] merge_data_s;

    assign range_err_s = BOUNDS_EN & ((req_addr >> 2) >= DEPTH_LIMIT);
    assign req_err_s   = is_misaligned(req_size, req_addr[1:0]) | range_err_s;
    assign accept_s    = (state_r == IDLE) & req_valid;
    assign word_idx_r  = addr_r >> 2;

    // Lane logic works on the latched request; mem_rdata is live in CAP/WR.
    lsu_lane_unit u_lane (
        .addr_lo      (addr_r[1:0]),
        .size         (size_r),
        .load_unsigned(unsigned_r),
        .rdata        (mem_rdata),
        .wdata        (wdata_r),
        .load_data    (load_data_s),
        .merge_data   (merge_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and memory-side decode.
    always_comb begin
        state_next_s = state_r;
        req_ready_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    if (req_err_s) begin
                        state_next_s = RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_next_s = WR;
                    end else begin
                        state_next_s = RD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                mem_read_s   = 1'b1;
                mem_addr_s   = word_idx_r;
                state_next_s = write_r ? WR : CAP;
            end
            CAP: begin
                mem_addr_s   = word_idx_r;
                state_next_s = RESP;
            end
            WR: begin
                // Word stores pass wdata straight through the merge.
                mem_write_s  = 1'b1;
                mem_addr_s   = word_idx_r;
                mem_wdata_s  = merge_data_s;
                state_next_s = RESP;
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request latch, captured on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r    <= 1'b0;
            size_r     <= 2'd0;
            unsigned_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
        end else if (accept_s) begin
            write_r    <= req_write;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
        end else begin
            write_r    <= write_r;
            size_r     <= size_r;
            unsigned_r <= unsigned_r;
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
        end
    end

    // Response registers; data and error are cleared once the pulse is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else begin
            resp_valid_r <= (state_next_s == RESP);
            case (state_r)
                IDLE: begin
                    resp_err_r   <= req_valid & req_err_s;
                    resp_rdata_r <= '0;
                end
                CAP: begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= load_data_s;
                end
                RESP: begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                end
                default: begin
                    resp_err_r   <= resp_err_r;
                    resp_rdata_r <= resp_rdata_r;
                end
            endcase
        end
    end

    // Reset gates the memory strobes immediately so a write in flight is dropped.
    assign req_ready  = req_ready_s & ~rst;
    assign mem_read   = mem_read_s  & ~rst;
    assign mem_write  = mem_write_s & ~rst;
    assign mem_addr   = rst ? '0 : mem_addr_s;
    assign mem_wdata  = rst ? '0 : mem_wdata_s;

    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule
